// File: rtl/addr_fifo_reader.sv
// Pops addresses from the address FIFO and issues them on a valid/ready request channel.
// Optional alignment check is enabled by defining ADDR_FIFO_READER_ALIGN_CHECK_EN.
module addr_fifo_reader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clr_cnt,
  input  logic [ADDR_W-1:0] addr_fifo_dout,
  input  logic              addr_fifo_empty,
  output logic              addr_fifo_rd,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              load_s;
  logic              issue_s;
  logic              drop_s;
  logic              misalign_s;
  logic              more_s;
  logic [ADDR_W-1:0] req_addr_r;
  logic              rd_r;
  logic              valid_r;
  logic              busy_r;
  logic [CNT_W-1:0]  issued_r;
  logic [CNT_W-1:0]  err_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef ADDR_FIFO_READER_ALIGN_CHECK_EN
  assign misalign_s = (addr_fifo_dout[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // The empty check is made here so that READ only ever follows a non-empty FIFO.
  assign more_s = run && !addr_fifo_empty;

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    issue_s = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (more_s) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = LOAD;
      end
      LOAD: begin
        if (misalign_s) begin
          drop_s  = 1'b1;
          state_s = more_s ? READ : IDLE;
        end else begin
          load_s  = 1'b1;
          state_s = SEND;
        end
      end
      SEND: begin
        if (req_ready) begin
          issue_s = 1'b1;
          state_s = more_s ? READ : IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with registered strobes decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      rd_r    <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rd_r    <= (state_s == READ);
      valid_r <= (state_s == SEND);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Request address capture; held for the whole SEND phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr_r <= {ADDR_W{1'b0}};
    end else if (load_s) begin
      req_addr_r <= addr_fifo_dout;
    end
  end

  // Saturating status counters; clear has priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_r <= {CNT_W{1'b0}};
      err_r    <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      issued_r <= {CNT_W{1'b0}};
      err_r    <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        issued_r <= sat_inc(issued_r);
      end
      if (drop_s) begin
        err_r <= sat_inc(err_r);
      end
    end
  end

  assign addr_fifo_rd = rd_r;
  assign req_valid    = valid_r;
  assign busy         = busy_r;
  assign req_addr     = req_addr_r;
  assign issued_cnt   = issued_r;
  assign err_cnt      = err_r;

endmodule
